demux1x8_tdm: RTL
=================

// Module: demux1x8_tdm
// PURPOSE
//  - Inverse of the 8:1 select path: takes one time-multiplexed sample stream and distributes it into 8 lanes (1:8 demux).
//  - Lane select comes from an internal 3-bit slot counter that advances on each accepted sample.
//  - Samples fill a shadow buffer. The completed 8-lane frame is published to dout in one cycle.
//  - Sits downstream of a serialising 8:1 mux stage and restores the parallel word for consumers.
// PARAMETERS
//  - WIDTH  1  bits per sample/lane (1..32)
// PORTS
//  - clk          in   1          single clock, rising edge
//  - rst          in   1          asynchronous, active-high reset
//  - din          in   WIDTH      serial sample
//  - din_valid    in   1          din accepted this cycle when high (no back-pressure)
//  - frame_sync   in   1          present only with FRAME_SYNC_EN: forces current sample to slot 0
//  - dout         out  8*WIDTH    published frame; lane k = dout[k*WIDTH +: WIDTH]
//  - frame_valid  out  1          1-cycle pulse: dout updated this cycle
//  - lane_strobe  out  8          one-hot lane written by previous accepted sample; 0 otherwise
//  - slot         out  3          slot the next accepted sample will occupy
// BEHAVIOUR
//  - Reset (async, immediate): slot=0, shadow=0, dout=0, frame_valid=0, lane_strobe=0.
//  - Accept cycle (din_valid=1): shadow[slot]<=din; lane_strobe<=(1<<slot); slot<=slot+1.
//  - Slot arithmetic is 3-bit modulo: 7 wraps to 0.
//  - Idle cycle (din_valid=0): slot, shadow and dout hold; lane_strobe<=0; frame_valid<=0.
//  - Frame completion: accept with slot==7 gives, at the next edge:
//      - dout <= {din, shadow[6:0]}, with the lane-7 sample taken straight from din (no extra cycle);
//      - frame_valid <= 1 for exactly one cycle.
//  - Latency: din to lane_strobe = 1 clk. 8th sample of a frame to dout/frame_valid = 1 clk.
//  - dout changes only on frame completion. Partial frames are never visible on dout.
//  - Back-to-back frames: din_valid held high gives one frame_valid pulse every 8 clks, with no gap.
//  - Reset mid-frame: partial shadow is discarded. Counting restarts at slot 0 after rst deasserts.
//  - Control is a pure 8-state slot counter (S0..S7 = slot value). Transitions occur only on din_valid.
// CONFIGURATION
//  - FRAME_SYNC_EN defined:
//      - port frame_sync exists.
//      - frame_sync=1 with din_valid=1: sample stored in lane 0, slot<=1, lane_strobe<=8'h01.
//      - Any partial frame in shadow is abandoned (no frame_valid). Stale lanes 1..7 are overwritten as the new frame fills.
//      - frame_sync=1 with din_valid=0: slot<=0. Shadow and outputs hold.
//      - frame_sync and slot==7 with din_valid=1: sync wins. No frame_valid, and the sample goes to lane 0.
//  - FRAME_SYNC_EN undefined: no frame_sync port. Framing is purely by count from reset.
// TESTING
//  - T1 reset:
//      - rst pulse mid-stream -> dout=0, slot=0, frame_valid=0, lane_strobe=0 immediately, without waiting for clk.
//  - T2 full frame (WIDTH=4):
//      - din=0..7 on 8 consecutive valid cycles -> lane_strobe walks 01,02,..,80.
//      - 1 clk after the 8th sample, dout=32'h76543210 and frame_valid=1 for 1 clk.
//  - T3 gapped input:
//      - same 8 samples with din_valid toggling 1/0 -> identical dout.
//      - frame_valid appears 1 clk after the 8th valid sample; slot holds during gaps.
//  - T4 back-to-back:
//      - 24 continuous valid samples -> 3 frame_valid pulses exactly 8 clks apart.
//      - each dout matches its 8-sample group; no pulse between them.
//  - T5 reset mid-frame:
//      - 5 samples, then rst, then 8 samples A..H -> dout={H,G,F,E,D,C,B,A}.
//      - no frame_valid from the aborted frame.
//  - T6 (FRAME_SYNC_EN):
//      - 3 samples, then sync+din=9, then 7 samples -> lane_strobe=01 on the sync cycle.
//      - frame_valid once, with lane0=9; the earlier 3 samples are absent from dout.

Source files
------------

// File: rtl/demux1x8_tdm.sv
// ---------------------------------------------------------------------------
// demux1x8_tdm
//
// Purpose:
//   1:8 time-division demultiplexer. A serial sample stream (one sample per
//   accepted cycle) is distributed over 8 lanes. A 3-bit slot counter picks
//   the lane for each accepted sample. Samples collect in a shadow buffer.
//   When the 8th sample of a frame arrives, the whole frame is published to
//   dout in a single cycle. Consumers therefore never see a partial frame.
//
// Optional feature:
//   FRAME_SYNC_EN - when defined, adds the frame_sync input. frame_sync
//                   realigns the slot counter to lane 0 and abandons any
//                   partial frame.
//
// Ports:
//   clk          in   1         rising-edge clock
//   rst          in   1         asynchronous, active-high reset
//   din          in   WIDTH     serial sample
//   din_valid    in   1         din accepted this cycle (no back-pressure)
//   frame_sync   in   1         (FRAME_SYNC_EN only) force sample to slot 0
//   dout         out  8*WIDTH   published frame, lane k = dout[k*WIDTH +: WIDTH]
//   frame_valid  out  1         one-cycle pulse: dout updated this cycle
//   lane_strobe  out  8         one-hot lane written by previous accepted sample
//   slot         out  3         slot the next accepted sample will occupy;
//                               this is also the FSM state, exposed for debug
//
// Handshake: din_valid is a valid-only strobe. There is no ready, and every
// cycle with din_valid=1 consumes din exactly once.
// ---------------------------------------------------------------------------
module demux1x8_tdm #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
`ifdef FRAME_SYNC_EN
  input  logic               frame_sync,
`endif
  output logic [8*WIDTH-1:0] dout,
  output logic               frame_valid,
  output logic [7:0]         lane_strobe,
  output logic [2:0]         slot
);

  // The FSM state is the slot counter itself. S0..S7 map directly to the slot value.
  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5,
    S6 = 3'd6,
    S7 = 3'd7
  } slot_e;

  slot_e              state_q;
  slot_e              state_d;
  logic [WIDTH-1:0]   shadow_q [8];
  logic [WIDTH-1:0]   shadow_d [8];
  logic [8*WIDTH-1:0] dout_d;
  logic               frame_valid_d;
  logic [7:0]         lane_strobe_d;
  logic               sync;

`ifdef FRAME_SYNC_EN
  assign sync = frame_sync;
`else
  assign sync = 1'b0;
`endif

  assign slot = state_q;

  // Next-state, shadow and output logic.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    dout_d        = dout;
    frame_valid_d = 1'b0;
    lane_strobe_d = 8'h00;

    if (din_valid) begin
      if (sync) begin
        // Realign: this sample starts a new frame in lane 0. Lanes 1..7 of
        // the shadow keep stale data until the new frame overwrites them.
        // No publish happens, even if the counter was at slot 7.
        shadow_d[0]   = din;
        lane_strobe_d = 8'h01;
        state_d       = S1;
      end else begin
        shadow_d[state_q] = din;
        lane_strobe_d     = 8'h01 << state_q;
        case (state_q)
          S0:      state_d = S1;
          S1:      state_d = S2;
          S2:      state_d = S3;
          S3:      state_d = S4;
          S4:      state_d = S5;
          S5:      state_d = S6;
          S6:      state_d = S7;
          S7:      state_d = S0;
          default: state_d = S0;
        endcase
        if (state_q == S7) begin
          // The lane-7 sample bypasses the shadow so the frame publishes on
          // the same edge that accepts it.
          for (int k = 0; k < 7; k++) begin
            dout_d[k*WIDTH +: WIDTH] = shadow_q[k];
          end
          dout_d[7*WIDTH +: WIDTH] = din;
          frame_valid_d            = 1'b1;
        end
      end
    end else if (sync) begin
      // A sync on an idle cycle only realigns the counter.
      state_d = S0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S0;
      dout        <= '0;
      frame_valid <= 1'b0;
      lane_strobe <= 8'h00;
      for (int k = 0; k < 8; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      dout        <= dout_d;
      frame_valid <= frame_valid_d;
      lane_strobe <= lane_strobe_d;
      for (int k = 0; k < 8; k++) begin
        shadow_q[k] <= shadow_d[k];
      end
    end
  end

endmodule
